marquee_scheduler: RTL

//   Drives a multiplexed row of 16-segment digits as a scrolling marquee.

---
 rtl/marquee_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/marquee_scheduler.sv
// marquee_scheduler
//   Scrolling marquee driver for a multiplexed row of 16-segment digits.
//   A host fills an ASCII message buffer. The block time-multiplexes the
//   digits: each slot is BLANK_CYCLES all-off cycles followed by REFRESH_DIV
//   cycles with one digit enabled. The character for a digit is latched into
//   `ascii` on the edge that enters that digit's BLANK phase.
//   The message scrolls left one position every SCROLL_DIV cycles while `run`
//   is high. NUM_DIGITS trailing spaces let the text clear the display
//   before it wraps.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   wr_en       message buffer write strobe
//   wr_addr     message buffer write address
//   wr_data     ASCII byte to write
//   msg_len     message length in characters (0 = blank display)
//   run         1 = scroll, 0 = freeze offset (refresh keeps running)
//   ascii       registered character code for the character ROM
//   digit_en_n  registered one-hot active-low digit enables
//   wrap_pulse  one-cycle pulse when the scroll offset wraps to 0
//   dbg_state   refresh FSM state (0 = BLANK, 1 = DRIVE)
//
// Handshake: there is no valid/ready flow here. A write is taken on every
// rising edge where wr_en is high. msg_len and run are sampled on every edge.
module marquee_scheduler #(
  parameter int NUM_DIGITS   = 4,
  parameter int BUF_DEPTH    = 32,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int SCROLL_DIV   = 250000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [$clog2(BUF_DEPTH)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic [$clog2(BUF_DEPTH):0]   msg_len,
  input  logic                         run,
  output logic [7:0]                   ascii,
  output logic [NUM_DIGITS-1:0]        digit_en_n,
  output logic                         wrap_pulse,
  output logic                         dbg_state
);

  localparam int AW   = $clog2(BUF_DEPTH);
  localparam int LENW = AW + 1;
  localparam int LMAX = BUF_DEPTH + NUM_DIGITS;
  localparam int LW   = $clog2(LMAX + 1);
  localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TMAX = (BLANK_CYCLES > REFRESH_DIV) ? BLANK_CYCLES : REFRESH_DIV;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int SW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  logic [7:0]            r_mem [BUF_DEPTH];
  state_t                r_state;
  logic [TW-1:0]         r_cnt;
  logic [DW-1:0]         r_digit;
  logic [7:0]            r_ascii;
  logic [NUM_DIGITS-1:0] r_en_n;
  logic [LENW-1:0]       r_msg_len;
  logic [LW-1:0]         r_offset;
  logic [SW-1:0]         r_scnt;
  logic                  r_wrap;

  state_t                w_state_nxt;
  logic [TW-1:0]         w_cnt_nxt;
  logic [DW-1:0]         w_digit_nxt;
  logic [NUM_DIGITS-1:0] w_en_n_nxt;
  logic                  w_enter_blank;
  logic [LENW-1:0]       w_len;
  logic [LW-1:0]         w_l;
  logic [LW:0]           w_idx_raw;
  logic [LW:0]           w_idx;
  logic [7:0]            w_char;

  assign ascii      = r_ascii;
  assign digit_en_n = r_en_n;
  assign wrap_pulse = r_wrap;
  assign dbg_state  = r_state;

  // Message buffer: synchronous write, asynchronous read, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Effective length and virtual stream length (message plus trailing blanks).
  assign w_len = (r_msg_len > LENW'(BUF_DEPTH)) ? LENW'(BUF_DEPTH) : r_msg_len;
  assign w_l   = LW'(w_len) + LW'(NUM_DIGITS);

  // Stream index for the digit about to be entered. offset < L and
  // digit < NUM_DIGITS <= L, so a single subtract brings it back into range.
  always_comb begin
    w_idx_raw = {1'b0, r_offset} + (LW + 1)'(w_digit_nxt);
    w_idx     = w_idx_raw;
    if (w_idx_raw >= (LW + 1)'(w_l)) w_idx = w_idx_raw - (LW + 1)'(w_l);
    w_char = 8'h20;
    if (w_idx < (LW + 1)'(w_len)) w_char = r_mem[w_idx[AW-1:0]];
  end

  // Refresh FSM: next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + TW'(1);
    w_digit_nxt   = r_digit;
    w_en_n_nxt    = r_en_n;
    w_enter_blank = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == TW'(BLANK_CYCLES - 1)) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
          w_en_n_nxt  = ~(NUM_DIGITS'(1) << r_digit);
        end
      end
      ST_DRIVE: begin
        if (r_cnt == TW'(REFRESH_DIV - 1)) begin
          w_state_nxt   = ST_BLANK;
          w_cnt_nxt     = '0;
          w_digit_nxt   = (r_digit == DW'(NUM_DIGITS - 1)) ? '0 : r_digit + DW'(1);
          w_en_n_nxt    = '1;
          w_enter_blank = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
        w_en_n_nxt  = '1;
      end
    endcase
  end

  // Refresh FSM: state register. ascii is latched only on BLANK entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_digit <= '0;
      r_en_n  <= '1;
      r_ascii <= 8'h20;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_digit <= w_digit_nxt;
      r_en_n  <= w_en_n_nxt;
      if (w_enter_blank) r_ascii <= w_char;
    end
  end

  // Scroll offset. A change of msg_len restarts the scroll from offset 0
  // without a wrap pulse, and takes priority over a scroll step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg_len <= '0;
      r_offset  <= '0;
      r_scnt    <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_msg_len <= msg_len;
      r_wrap    <= 1'b0;
      if (msg_len != r_msg_len) begin
        r_offset <= '0;
        r_scnt   <= '0;
      end else if (run) begin
        if (r_scnt == SW'(SCROLL_DIV - 1)) begin
          r_scnt <= '0;
          if (r_offset == LW'(w_l - LW'(1))) begin
            r_offset <= '0;
            r_wrap   <= 1'b1;
          end else begin
            r_offset <= r_offset + LW'(1);
          end
        end else begin
          r_scnt <= r_scnt + SW'(1);
        end
      end else begin
        r_scnt <= '0;
      end
    end
  end

endmodule
